// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared pipeline definitions for the hazard scoreboard:
//   state_e    - scoreboard FSM encoding (RUN=0, STALL=1, FLUSH=2)
//   slot_t     - one in-flight writer slot {valid, rd[4:0]}
//   REG_ZERO   - architectural zero register; never a hazard, never busy
//   slot_match - true when a slot holds a live write to a nonzero register r
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.valid && (r != REG_ZERO) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_slot_pipe.sv
// ---------------------------------------------------------------------------
// hsb_slot_pipe
// Shift register of in-flight writer slots. Index 0 is R, 1 is E, and the
// last index is W (with the default NSLOT=3). Every cycle each slot moves one
// stage down and slot 0 loads new_entry.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset, clears every slot
//   clear_r   in   kill the instruction currently in slot 0 instead of
//                  shifting it onward (it never reaches slot 1)
//   new_entry in   slot_t loaded into slot 0
//   slots     out  packed array of all slot contents
// ---------------------------------------------------------------------------
module hsb_slot_pipe
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSLOT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_r,
  input  slot_t                 new_entry,
  output slot_t [NSLOT-1:0]     slots
);

  slot_t [NSLOT-1:0] slots_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
    end else begin
      slots_q[0] <= new_entry;
      for (int i = 1; i < NSLOT; i++) begin
        // A killed R entry is replaced by an empty slot; older entries
        // (such as the branch sitting in E) keep shifting unchanged.
        if (i == 1 && clear_r) begin
          slots_q[i] <= '0;
        end else begin
          slots_q[i] <= slots_q[i-1];
        end
      end
    end
  end

  assign slots = slots_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Read-after-write hazard scoreboard for a short in-order pipeline. Tracks the
// destination registers of in-flight writers (slots R, E, W), stalls Decode
// while a source register is still pending, and flushes younger stages when a
// branch resolves taken in Execute.
//
// Parameters:
//   NSLOT      in-flight writer slots tracked (R, E, W)
//   FLUSH_CYC  number of cycles the FLUSH state lasts
//
// Configuration macro:
//   HAZARD_SCOREBOARD_WB_FWD_EN - writeback forwarding exists, so the W slot
//   no longer causes a hazard (it still shows in busy).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   id_valid   in   Decode holds a valid instruction
//   id_rs1/2   in   Decode source registers
//   id_rd      in   Decode destination register
//   id_wr      in   Decode instruction writes id_rd
//   br_taken   in   branch resolved taken in Execute this cycle
//   stall      out  hold IFU and F/D, bubble into R (combinational)
//   flush      out  kill F/D, D/R, R/E (combinational)
//   issue      out  Decode instruction advances into R (combinational)
//   busy       out  bit n set when a valid slot targets register n
//   state_o    out  FSM state (RUN=0, STALL=1, FLUSH=2)
//   stall_cnt  out  saturating count of stall cycles
//
// Handshake: issue is the "ready" for the Decode instruction; an instruction
// is consumed exactly in a cycle where id_valid=1 and issue=1, otherwise
// Decode must hold it unchanged.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSLOT     = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr,
  input  logic        br_taken,
  output logic        stall,
  output logic        flush,
  output logic        issue,
  output logic [31:0] busy,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt
);

  // A FLUSH of zero cycles is meaningless; treat it as one.
  localparam int FLUSH_LOAD = (FLUSH_CYC < 1) ? 1 : FLUSH_CYC;
  localparam int FCW        = $clog2(FLUSH_LOAD + 1);

`ifdef HAZARD_SCOREBOARD_WB_FWD_EN
  // The oldest slot (W) is forwarded, so it is left out of hazard detection.
  localparam int NHAZ = NSLOT - 1;
`else
  localparam int NHAZ = NSLOT;
`endif

  state_e            state_q;
  logic [FCW-1:0]    flush_cnt_q;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;

  slot_t [NSLOT-1:0] slots;
  slot_t             new_entry;
  logic              hit;
  logic              hazard;
  logic [31:0]       busy_v;

  // -------------------------------------------------------------------------
  // Slot shift register
  // -------------------------------------------------------------------------
  hsb_slot_pipe #(
    .NSLOT (NSLOT)
  ) u_slot_pipe (
    .clk       (clk),
    .rst       (rst),
    .clear_r   (flush),
    .new_entry (new_entry),
    .slots     (slots)
  );

  // -------------------------------------------------------------------------
  // Hazard detection and busy vector
  // -------------------------------------------------------------------------
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NHAZ; i++) begin
      if (slot_match(slots[i], id_rs1) || slot_match(slots[i], id_rs2)) begin
        hit = 1'b1;
      end
    end
  end

  // Nothing issued during FLUSH is real, so it cannot be hazarded.
  assign hazard = id_valid && (state_q != ST_FLUSH) && hit;

  always_comb begin
    busy_v = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slots[i].valid && (slots[i].rd != REG_ZERO)) begin
        busy_v[slots[i].rd] = 1'b1;
      end
    end
  end

  assign busy = busy_v;

  // -------------------------------------------------------------------------
  // Pipeline control (same-cycle). A taken branch wins over a hazard.
  // -------------------------------------------------------------------------
  assign flush = br_taken;
  assign stall = hazard && !br_taken;
  assign issue = id_valid && !hazard && !br_taken && (state_q != ST_FLUSH);

  always_comb begin
    new_entry = '0;
    if (issue && id_wr && (id_rd != REG_ZERO)) begin
      new_entry.valid = 1'b1;
      new_entry.rd    = id_rd;
    end
  end

  // Written every cycle so the register always tracks its next value.
  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ?
                       (stall_cnt_q + 16'd1) : stall_cnt_q;

  // -------------------------------------------------------------------------
  // FSM, FLUSH down-counter and stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      unique case (state_q)
        ST_RUN, ST_STALL: begin
          if (br_taken) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FCW'(FLUSH_LOAD);
          end else if (hazard) begin
            state_q <= ST_STALL;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (br_taken) begin
            // A new taken branch restarts the full flush window.
            flush_cnt_q <= FCW'(FLUSH_LOAD);
          end else if (flush_cnt_q <= FCW'(1)) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FCW'(1);
          end
        end
        default: begin
          state_q     <= ST_RUN;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

  assign state_o   = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
